// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side byte packer.
package fifo_rd_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  localparam int unsigned MAX_LANES = 32;

  // Ceiling log2, used for lane-index and counter widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Low n bits set: lane-valid mask for a word holding n lanes.
  function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned n);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-word valid/ready stream; master is the packer side.
interface fifo_rd_packer_if #(
  parameter int unsigned SIZE   = 8,
  parameter int unsigned PACK_N = 4
);
  logic [SIZE-1:0]        fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_ren;
  logic [SIZE*PACK_N-1:0] m_data;
  logic [PACK_N-1:0]      m_keep;
  logic                   m_valid;
  logic                   m_ready;

  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_ren, m_data, m_keep, m_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_ren, m_data, m_keep, m_valid
  );
endinterface

// File: rtl/fifo_rd_out_reg.sv
// Single-entry valid/ready output register with an emitted-word counter.
module fifo_rd_out_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] ld_data,
  input  logic [KW-1:0] ld_keep,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic [KW-1:0] m_keep,
  output logic [15:0]   words,
  output logic          free_c
);

  assign free_c = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      words   <= '0;
    end else if (ld) begin
      m_valid <= 1'b1;
      m_data  <= ld_data;
      m_keep  <= ld_keep;
      words   <= words + 16'd1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains bytes from the FIFO read port and packs PACK_N of them per output word,
// flushing partial words on request or after an idle timeout.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned PACK_N  = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             rclk_i,
  input  logic             rrst_i,
  input  logic             flush_i,
  output logic [15:0]      words_o,
  fifo_rd_packer_if.master bus
);

  localparam int unsigned LW = clog2(PACK_N);
  localparam int unsigned CW = LW + 1;
  localparam int unsigned TW = clog2(TIMEOUT + 1);
  localparam int unsigned DW = SIZE * PACK_N;

  pack_state_e                 state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic [PACK_N-1:0][SIZE-1:0] lanes_q, lanes_d;
  logic                        rd_vld_q;
  logic                        pend_q, pend_d;
  logic                        ren_c, ld_c, free_c;
  logic                        has_data_c, flush_c;
  logic [PACK_N-1:0]           keep_c;

  assign has_data_c   = (cnt_q != '0) || rd_vld_q;
  assign flush_c      = pend_q || flush_i || (tmo_q == TW'(TIMEOUT));
  assign keep_c       = PACK_N'(keep_mask(32'(cnt_q)));
  assign bus.fifo_ren = ren_c;

  always_ff @(posedge rclk_i) begin
    if (rrst_i) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      tmo_q    <= '0;
      lanes_q  <= '0;
      rd_vld_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      lanes_q  <= lanes_d;
      rd_vld_q <= ren_c;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    pend_d  = pend_q || flush_i;
    tmo_d   = '0;
    ren_c   = 1'b0;
    ld_c    = 1'b0;

    case (state_q)
      FILL: begin
        // Stop issuing reads once a flush is owed, so only the in-flight byte lands first.
        ren_c = !rrst_i && !bus.fifo_empty
             && ((cnt_q + CW'(rd_vld_q)) < CW'(PACK_N))
             && !(flush_c && has_data_c);
        if (rd_vld_q) begin
          lanes_d[cnt_q[LW-1:0]] = bus.fifo_dout;
          cnt_d                  = cnt_q + CW'(1);
        end
        if (rd_vld_q && (cnt_q == CW'(PACK_N - 1))) begin
          state_d = HOLD;
          pend_d  = 1'b0;
        end else if (flush_c && (cnt_q != '0) && !rd_vld_q) begin
          state_d = HOLD;
          pend_d  = 1'b0;
        end else if (!has_data_c) begin
          pend_d = 1'b0;
        end
        if ((state_d == FILL) && (cnt_q != '0) && (cnt_q < CW'(PACK_N))
            && !rd_vld_q && bus.fifo_empty) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      HOLD: begin
        if (free_c) begin
          ld_c    = 1'b1;
          cnt_d   = '0;
          lanes_d = '0;
          state_d = FILL;
        end
      end
    endcase
  end

  fifo_rd_out_reg #(
    .DW(DW),
    .KW(PACK_N)
  ) u_out (
    .clk    (rclk_i),
    .rst    (rrst_i),
    .ld     (ld_c),
    .ld_data(DW'(lanes_q)),
    .ld_keep(keep_c),
    .m_ready(bus.m_ready),
    .m_valid(bus.m_valid),
    .m_data (bus.m_data),
    .m_keep (bus.m_keep),
    .words  (words_o),
    .free_c (free_c)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: queue-based FIFO model, word monitor
// and a byte-stream reference built from the bytes pushed into the FIFO.
module tb_fifo_rd_packer;

  localparam int unsigned SIZE    = 8;
  localparam int unsigned PACK_N  = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DW      = SIZE * PACK_N;

  logic            rclk  = 1'b0;
  logic            rrst  = 1'b1;
  logic            flush = 1'b0;
  logic            mrdy  = 1'b0;
  logic [15:0]     words;
  logic            emp   = 1'b1;
  logic [SIZE-1:0] dout  = '0;

  int n_checks  = 0;
  int n_fail    = 0;
  int ren_viol  = 0;
  int underflow = 0;

  logic [SIZE-1:0]   fq[$];
  logic [DW-1:0]     got_d[$];
  logic [PACK_N-1:0] got_k[$];

  fifo_rd_packer_if #(.SIZE(SIZE), .PACK_N(PACK_N)) bus ();

  assign bus.fifo_empty = emp;
  assign bus.fifo_dout  = dout;
  assign bus.m_ready    = mrdy;

  fifo_rd_packer #(.SIZE(SIZE), .PACK_N(PACK_N), .TIMEOUT(TIMEOUT)) dut (
    .rclk_i (rclk),
    .rrst_i (rrst),
    .flush_i(flush),
    .words_o(words),
    .bus    (bus)
  );

  always #5 rclk = ~rclk;

  // FIFO read port model: data one cycle after ren, registered empty flag.
  always @(posedge rclk) begin
    if (bus.fifo_ren) begin
      if (fq.size() == 0) underflow++;
      else dout <= fq.pop_front();
    end
    emp <= (fq.size() == 0);
  end

  always @(negedge rclk) begin
    if (bus.fifo_ren && bus.fifo_empty) ren_viol++;
    if (!rrst && bus.m_valid && mrdy) begin
      got_d.push_back(bus.m_data);
      got_k.push_back(bus.m_keep);
    end
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && got_d.size() < n; i++) step();
    ok = (got_d.size() >= n);
  endtask

  function automatic logic [DW-1:0] mkword(input logic [SIZE-1:0] b[$], input int first, input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r = r | (DW'(b[first + j]) << (SIZE * j));
    return r;
  endfunction

  task automatic test_reset();
    rrst = 1'b1; mrdy = 1'b0; flush = 1'b0;
    repeat (3) step();
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
    n_checks++; if (bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_ren got %b want 0", bus.fifo_ren); end
    n_checks++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", bus.m_data); end
    n_checks++; if (bus.m_keep !== '0) begin n_fail++; $display("FAIL reset_m_keep got %h want 0", bus.m_keep); end
    n_checks++; if (words !== 16'd0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words); end
    rrst = 1'b0;
    step();
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_m_valid got %b want 0", bus.m_valid); end
  endtask

  task automatic test_full_word();
    logic [SIZE-1:0] b[$];
    int first_ren = -1, first_v = -1;
    bit ok;
    got_d.delete(); got_k.delete();
    mrdy = 1'b1;
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (b[i]) fq.push_back(b[i]);
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.fifo_ren && first_ren < 0) first_ren = c;
      if (bus.m_valid && first_v < 0) first_v = c;
    end
    wait_words(1, 10, ok);
    n_checks++; if (!ok || got_d.size() != 1) begin n_fail++; $display("FAIL full_count got %0d want 1", got_d.size()); end
    if (ok) begin
      n_checks++; if (got_d[0] !== mkword(b, 0, 4)) begin n_fail++; $display("FAIL full_data got %h want %h", got_d[0], mkword(b, 0, 4)); end
      n_checks++; if (got_k[0] !== 4'hF) begin n_fail++; $display("FAIL full_keep got %h want f", got_k[0]); end
    end
    n_checks++; if (first_v - first_ren != int'(PACK_N) + 2) begin n_fail++; $display("FAIL full_latency got %0d want %0d", first_v - first_ren, PACK_N + 2); end
    n_checks++; if (words !== 16'd1) begin n_fail++; $display("FAIL full_words got %0d want 1", words); end
    n_checks++; if (ren_viol != 0 || underflow != 0) begin n_fail++; $display("FAIL full_ren_empty got %0d/%0d want 0/0", ren_viol, underflow); end
  endtask

  task automatic test_timeout();
    logic [SIZE-1:0] b[$];
    int first_v = -1;
    bit ok;
    logic [15:0] w0;
    got_d.delete(); got_k.delete();
    w0 = words;
    mrdy = 1'b1;
    b = '{8'hA1, 8'hB2};
    foreach (b[i]) fq.push_back(b[i]);
    for (int c = 0; c < 60 && first_v < 0; c++) begin
      step();
      if (bus.m_valid) first_v = c;
    end
    n_checks++; if (first_v < int'(TIMEOUT) || first_v > int'(TIMEOUT) + 10) begin n_fail++; $display("FAIL tmo_delay got %0d want %0d..%0d", first_v, TIMEOUT, TIMEOUT + 10); end
    wait_words(1, 10, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_word got %0d words want 1", got_d.size()); end
    if (ok) begin
      n_checks++; if (got_d[0] !== 32'h0000B2A1) begin n_fail++; $display("FAIL tmo_data got %h want 0000b2a1", got_d[0]); end
      n_checks++; if (got_k[0] !== 4'h3) begin n_fail++; $display("FAIL tmo_keep got %h want 3", got_k[0]); end
    end
    n_checks++; if (words !== 16'(w0 + 16'd1)) begin n_fail++; $display("FAIL tmo_words got %0d want %0d", words, w0 + 16'd1); end
  endtask

  task automatic test_flush();
    bit ok;
    logic [15:0] w0;
    got_d.delete(); got_k.delete();
    w0 = words;
    mrdy = 1'b1;
    fq.push_back(8'h05);
    repeat (3) step();
    flush = 1'b1; step(); flush = 1'b0;
    wait_words(1, 12, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_word got %0d words want 1", got_d.size()); end
    if (ok) begin
      n_checks++; if (got_d[0] !== 32'h00000005) begin n_fail++; $display("FAIL flush_data got %h want 00000005", got_d[0]); end
      n_checks++; if (got_k[0] !== 4'h1) begin n_fail++; $display("FAIL flush_keep got %h want 1", got_k[0]); end
    end
    repeat (4) step();
    got_d.delete(); got_k.delete();
    w0 = words;
    flush = 1'b1; step(); flush = 1'b0;
    repeat (30) step();
    n_checks++; if (got_d.size() != 0 || bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %0d words want 0", got_d.size()); end
    n_checks++; if (words !== w0) begin n_fail++; $display("FAIL flush_empty_words got %0d want %0d", words, w0); end
  endtask

  task automatic test_backpressure();
    logic [SIZE-1:0] b[$];
    bit ok;
    int seen = 0;
    logic [15:0] w0;
    got_d.delete(); got_k.delete();
    w0 = words;
    mrdy = 1'b0;
    for (int i = 0; i < 16; i++) begin b.push_back(SIZE'(i)); fq.push_back(SIZE'(i)); end
    for (int c = 0; c < 30 && !bus.m_valid; c++) step();
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== mkword(b, 0, 4)) begin
        n_fail++; $display("FAIL hold_stable cyc %0d got v=%b d=%h want v=1 d=%h", c, bus.m_valid, bus.m_data, mkword(b, 0, 4));
      end
    end
    mrdy = 1'b1;
    wait_words(4, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_count got %0d want 4", got_d.size()); end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got_d[k] !== mkword(b, 4 * k, 4) || got_k[k] !== 4'hF) begin
          n_fail++; $display("FAIL bp_word%0d got %h/%h want %h/f", k, got_d[k], got_k[k], mkword(b, 4 * k, 4));
        end
        seen++;
      end
    end
    n_checks++; if (words !== 16'(w0 + 16'(seen))) begin n_fail++; $display("FAIL bp_words got %0d want %0d", words, w0 + 16'(seen)); end
  endtask

  task automatic test_reset_mid();
    logic [SIZE-1:0] b[$];
    bit ok;
    mrdy = 1'b1;
    fq.push_back(8'hC1); fq.push_back(8'hC2);
    repeat (4) step();
    got_d.delete(); got_k.delete();
    rrst = 1'b1;
    step();
    n_checks++; if (bus.m_valid !== 1'b0 || bus.fifo_ren !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got v=%b ren=%b want 0/0", bus.m_valid, bus.fifo_ren); end
    step();
    rrst = 1'b0;
    b = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    foreach (b[i]) fq.push_back(b[i]);
    wait_words(1, 40, ok);
    repeat (10) step();
    n_checks++; if (!ok || got_d.size() != 1) begin n_fail++; $display("FAIL midrst_count got %0d want 1", got_d.size()); end
    if (ok) begin
      n_checks++; if (got_d[0] !== mkword(b, 0, 4) || got_k[0] !== 4'hF) begin n_fail++; $display("FAIL midrst_word got %h/%h want %h/f", got_d[0], got_k[0], mkword(b, 0, 4)); end
    end
    n_checks++; if (words !== 16'd1) begin n_fail++; $display("FAIL midrst_words got %0d want 1", words); end
  endtask

  task automatic test_random();
    logic [SIZE-1:0] exp[$];
    logic [SIZE-1:0] got[$];
    logic [15:0] w0;
    bit wdone = 1'b0;
    int nbytes;
    int nb = 0;
    got_d.delete(); got_k.delete();
    w0 = words;
    fork
      begin
        while (nb < 300) begin
          #15;
          if ($urandom_range(0, 3) != 0) begin
            logic [SIZE-1:0] v;
            v = SIZE'($urandom);
            fq.push_back(v); exp.push_back(v); nb++;
          end
        end
        wdone = 1'b1;
      end
      begin
        while (!wdone) begin
          step();
          mrdy  = ($urandom_range(0, 3) != 0);
          flush = ($urandom_range(0, 19) == 0);
        end
      end
    join
    flush = 1'b0; mrdy = 1'b1;
    nbytes = 0;
    for (int c = 0; c < 600 && nbytes < exp.size(); c++) begin
      step();
      nbytes = 0;
      foreach (got_k[i]) nbytes += $countones(got_k[i]);
    end
    foreach (got_d[i]) begin
      logic [DW-1:0] d;
      int kk;
      d = got_d[i];
      kk = int'(got_k[i]);
      n_checks++;
      if (kk == 0 || ((kk + 1) & kk) != 0) begin n_fail++; $display("FAIL rnd_keep word %0d got %h want contiguous nonzero", i, got_k[i]); end
      for (int j = 0; j < int'(PACK_N); j++) begin
        if (got_k[i][j]) got.push_back(d[SIZE*j +: SIZE]);
        else begin
          n_checks++;
          if (d[SIZE*j +: SIZE] !== '0) begin n_fail++; $display("FAIL rnd_pad word %0d lane %0d got %h want 0", i, j, d[SIZE*j +: SIZE]); end
        end
      end
    end
    n_checks++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL rnd_len got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rnd_byte %0d got %h want %h", i, got[i], exp[i]); end
    end
    n_checks++; if (words !== 16'(w0 + 16'(got_d.size()))) begin n_fail++; $display("FAIL rnd_words got %0d want %0d", words, w0 + 16'(got_d.size())); end
    n_checks++; if (ren_viol != 0 || underflow != 0) begin n_fail++; $display("FAIL rnd_ren_empty got %0d/%0d want 0/0", ren_viol, underflow); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_timeout();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
